// File: rtl/lcb_gate_ctrl_if.sv
// Bundle of per-domain request/status signals between the power manager and
// the local-clock-buffer gate controller. The master drives requests and the
// override. The slave (the controller) drives the enables and status.
interface lcb_gate_ctrl_if #(
  parameter int NUM_DOM = 4
);

  logic [NUM_DOM-1:0] req;
  logic [NUM_DOM-1:0] busy;
  logic               force_on;
  logic [NUM_DOM-1:0] lcb_en;
  logic [NUM_DOM-1:0] ack;
  logic               wake_busy;

  modport master (
    output req,
    output busy,
    output force_on,
    input  lcb_en,
    input  ack,
    input  wake_busy
  );

  modport slave (
    input  req,
    input  busy,
    input  force_on,
    output lcb_en,
    output ack,
    output wake_busy
  );

endinterface

// File: rtl/lcb_gate_ctrl.sv
// Local-clock-buffer gate controller.
// Each domain runs an OFF/WAKE/ON/IDLE FSM with an 8-bit down-counter.
// Only one domain may be waking at a time, which limits inrush current.
// The wake slot is handed out round-robin among OFF domains that are requesting.
// All outputs are registered. They are derived from the next state, so they
// line up with the state the domain enters on the same edge.
module lcb_gate_ctrl #(
  parameter int NUM_DOM  = 4,
  parameter int WAKE_CYC = 2,
  parameter int IDLE_CYC = 8
) (
  input  logic               iccad_clk,
  input  logic               iccad_rst_n,
  lcb_gate_ctrl_if.slave     bus
);

  localparam int GW = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_WAKE = 2'd1,
    S_ON   = 2'd2,
    S_IDLE = 2'd3
  } state_e;

  // Per-domain state and counters
  state_e             st_q  [NUM_DOM];
  state_e             st_d  [NUM_DOM];
  logic [7:0]         cnt_q [NUM_DOM];
  logic [7:0]         cnt_d [NUM_DOM];

  // Round-robin pointer and registered outputs
  logic [GW-1:0]      last_grant_q;
  logic [NUM_DOM-1:0] lcb_en_q;
  logic [NUM_DOM-1:0] lcb_en_d;
  logic [NUM_DOM-1:0] ack_q;
  logic [NUM_DOM-1:0] ack_d;
  logic               wake_busy_q;
  logic               wake_busy_d;

  // Arbitration signals
  logic [NUM_DOM-1:0] pend;
  logic               any_wake;
  logic               grant_vld;
  logic [GW-1:0]      grant_idx;
  logic [GW-1:0]      cand;

  // Domains waiting for the wake slot, and whether the slot is currently taken
  always_comb begin
    pend     = '0;
    any_wake = 1'b0;
    for (int i = 0; i < NUM_DOM; i++) begin
      if (st_q[i] == S_OFF && bus.req[i]) pend[i] = 1'b1;
      if (st_q[i] == S_WAKE)              any_wake = 1'b1;
    end
  end

  // Round-robin grant: search from last_grant+1, wrapping modulo NUM_DOM.
  // The slot is only handed out on an edge where nobody is waking. As a
  // result, there is one handover cycle between consecutive wakes.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    if (!any_wake) begin
      for (int k = 0; k < NUM_DOM; k++) begin
        cand = GW'((int'(last_grant_q) + 1 + k) % NUM_DOM);
        if (!grant_vld && pend[cand]) begin
          grant_vld = 1'b1;
          grant_idx = cand;
        end
      end
    end
  end

  // Per-domain next state and counter
  always_comb begin
    for (int i = 0; i < NUM_DOM; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      case (st_q[i])
        S_OFF: begin
          if (grant_vld && grant_idx == GW'(i)) begin
            st_d[i]  = S_WAKE;
            cnt_d[i] = 8'(WAKE_CYC);
          end
        end
        S_WAKE: begin
          // Wake always runs to completion, even if req drops meanwhile
          if (cnt_q[i] <= 8'd1) begin
            st_d[i]  = S_ON;
            cnt_d[i] = 8'd0;
          end else begin
            cnt_d[i] = cnt_q[i] - 8'd1;
          end
        end
        S_ON: begin
          if (!bus.req[i] && !bus.busy[i]) begin
            st_d[i]  = S_IDLE;
            cnt_d[i] = 8'(IDLE_CYC);
          end
        end
        S_IDLE: begin
          // Renewed demand wins over the timeout; force_on freezes the timer
          if (bus.req[i] || bus.busy[i]) begin
            st_d[i]  = S_ON;
            cnt_d[i] = 8'd0;
          end else if (bus.force_on) begin
            cnt_d[i] = cnt_q[i];
          end else if (cnt_q[i] <= 8'd1) begin
            st_d[i]  = S_OFF;
            cnt_d[i] = 8'd0;
          end else begin
            cnt_d[i] = cnt_q[i] - 8'd1;
          end
        end
        default: begin
          st_d[i]  = S_OFF;
          cnt_d[i] = 8'd0;
        end
      endcase
    end
  end

  // Output next values taken from next state. wake_busy also covers the
  // handover cycle, when a domain finishes waking while others are queued.
  always_comb begin
    lcb_en_d    = '0;
    ack_d       = '0;
    wake_busy_d = any_wake && (pend != '0);
    for (int i = 0; i < NUM_DOM; i++) begin
      lcb_en_d[i] = (st_d[i] != S_OFF) || bus.force_on;
      ack_d[i]    = (st_d[i] == S_ON);
      if (st_d[i] == S_WAKE) wake_busy_d = 1'b1;
    end
  end

  // State, counters, grant pointer and registered outputs
  always_ff @(posedge iccad_clk or negedge iccad_rst_n) begin
    if (!iccad_rst_n) begin
      for (int i = 0; i < NUM_DOM; i++) begin
        st_q[i]  <= S_OFF;
        cnt_q[i] <= 8'd0;
      end
      last_grant_q <= GW'(NUM_DOM - 1);
      lcb_en_q     <= '0;
      ack_q        <= '0;
      wake_busy_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_DOM; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      if (grant_vld) last_grant_q <= grant_idx;
      lcb_en_q    <= lcb_en_d;
      ack_q       <= ack_d;
      wake_busy_q <= wake_busy_d;
    end
  end

  assign bus.lcb_en    = lcb_en_q;
  assign bus.ack       = ack_q;
  assign bus.wake_busy = wake_busy_q;

endmodule

// File: doc/lcb_gate_ctrl.md
LCB_GATE_CTRL -- requirements
Module: lcb_gate_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_DOM, default 4: number of local-clock-buffer domains, legal range 1..16.
REQ-002 The block SHALL have parameter WAKE_CYC, default 2: cycles a domain spends in WAKE, legal range 1..255.
REQ-003 The block SHALL have parameter IDLE_CYC, default 8: cycles a domain spends in IDLE before shutoff, legal range 1..255.
REQ-004 The block SHALL have port iccad_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port iccad_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 The block SHALL have port req, input, NUM_DOM bits: per-domain clock request, level-sensitive.
REQ-007 The block SHALL have port busy, input, NUM_DOM bits: per-domain activity indication that blocks shutoff.
REQ-008 The block SHALL have port force_on, input, 1 bit: global override that keeps every clock enabled.
REQ-009 The block SHALL have port lcb_en, output, NUM_DOM bits: registered enable to each domain's local clock buffer.
REQ-010 The block SHALL have port ack, output, NUM_DOM bits: registered, meaning the domain clock is stable and usable.
REQ-011 The block SHALL have port wake_busy, output, 1 bit: registered, high while any domain is in WAKE.

Function
REQ-012 Each domain SHALL run its own FSM with states OFF, WAKE, ON and IDLE, plus an 8-bit down-counter.
REQ-013 OFF -> WAKE SHALL occur only when req[i]=1 and domain i holds the wake grant; the counter loads WAKE_CYC.
REQ-014 At most one domain SHALL be in WAKE at any time (inrush limit).
- A grant is issued only on an edge where no domain is in WAKE.
REQ-015 The wake grant SHALL be round-robin among OFF domains with req=1.
- Search starts at last_grant+1 and wraps modulo NUM_DOM.
- last_grant is updated on each grant and resets to NUM_DOM-1, so index 0 wins first.
REQ-016 In WAKE the counter SHALL decrement each edge; the domain SHALL enter ON on the edge after the counter equals 1, giving exactly WAKE_CYC cycles in WAKE.
- WAKE is completed even if req drops.
REQ-017 ON -> IDLE SHALL occur on an edge where req[i]=0 and busy[i]=0; the counter loads IDLE_CYC.
REQ-018 IDLE -> ON SHALL occur on any edge where req[i]=1 or busy[i]=1; this takes priority over timeout.
REQ-019 IDLE -> OFF SHALL occur after exactly IDLE_CYC cycles in IDLE with req[i]=0 and busy[i]=0 throughout.
REQ-020 While force_on=1 the IDLE counter SHALL hold its value, so no IDLE -> OFF transition occurs.
REQ-021 lcb_en[i] SHALL be registered and equal 1 when the next state is WAKE, ON or IDLE, or when force_on=1; otherwise 0.
REQ-022 ack[i] SHALL be registered and equal 1 exactly when domain i is in ON; force_on SHALL NOT affect ack.
REQ-023 A req[i] rising while domain i is OFF and waiting for the grant SHALL stay pending, with no timeout, until granted or req[i] falls.
REQ-024 req or busy on a domain in WAKE or ON SHALL have no effect beyond REQ-016 and REQ-017.

Reset
REQ-025 Asserting iccad_rst_n low SHALL immediately (asynchronously) force the following, regardless of state:
- every FSM to OFF and every counter to 0;
- last_grant to NUM_DOM-1;
- lcb_en=0, ack=0, wake_busy=0.
REQ-026 After deassertion, the first grant SHALL be evaluated on the first rising edge with iccad_rst_n=1.

Verification
REQ-027 The bench SHALL cover scenarios 1-6 below, with NUM_DOM=4, WAKE_CYC=2, IDLE_CYC=8, and edges counted from the first edge sampling the stimulus as edge 1.
- 1. req=4'b0001 at edge 1: lcb_en[0]=1 and wake_busy=1 after edge 1; ack[0]=1 and wake_busy=0 after edge 3.
- 2. req=4'b1111 at edge 1: WAKE entry for domains 0,1,2,3 after edges 1,4,7,10; ack after edges 3,6,9,12; wake_busy never drops between edges 1 and 12.
- 3. Domain 0 in ON, req=0 and busy=0 from edge n: ack[0]=0 after edge n; lcb_en[0]=0 after edge n+8.
- 4. As scenario 3, but busy[0]=1 at edge n+5: ack[0]=1 after edge n+5; lcb_en[0] never drops.
- 5. iccad_rst_n low between edges while domain 2 is in WAKE: lcb_en, ack and wake_busy are 0 before the next edge; after release with req=4'b0100, domain 2 re-wakes and ack[2]=1 after 3 edges.
- 6. force_on=1 with all domains OFF: lcb_en=4'b1111 after 1 edge and ack=0. force_on=1 with domain 1 in IDLE for 30 cycles: no shutoff; after force_on=0 the remaining IDLE cycles elapse, then OFF.
